// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared types, constants and forward encoder for ctrl_pipe
//
// Purpose: declares the default field widths, the stage record layout, the
// bubble constant and the youngest-match priority encoder used by both
// forwarding paths of ctrl_pipe.
// Ports: none (package).

package ctrl_pipe_pkg;

  // Defaults of the ctrl_pipe parameters.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_REGW  = 5;
  localparam int DEF_DEPTH = 3;

  // Largest supported depth. The encoder is sized for it, and callers pad
  // their match vectors up to this width.
  localparam int MAX_DEPTH = 8;
  localparam int FWD_W     = $clog2(MAX_DEPTH + 1);

  // One pipeline stage at the default widths. ctrl_pipe keeps each stage as
  // a flat vector with this same field order, {valid, wr, rd, ctrl}, so that
  // other WIDTH and REGW values also work.
  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [DEF_REGW-1:0]  rd;
    logic [DEF_WIDTH-1:0] ctrl;
  } stage_t;

  // A bubble is all zero. Its wr is 0, so it can never take part in a
  // forward match or a load-use hazard.
  localparam stage_t BUBBLE = '0;

  localparam logic [FWD_W-1:0] FWD_NONE = '0;

  // Returns k+1 for the lowest set bit k of match, or FWD_NONE if no bit is
  // set. Stage 0 is the youngest stage, so the lowest index must win.
  function automatic logic [FWD_W-1:0] fwd_encode(input logic [MAX_DEPTH-1:0] match);
    logic [FWD_W-1:0] enc;
    enc = FWD_NONE;
    for (int k = MAX_DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        enc = FWD_W'(k + 1);
      end
    end
    return enc;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one stage register of the control-word pipeline
//
// Purpose: holds one {valid, wr, rd, ctrl} record. clear has priority over
// load and writes a bubble (all zero). When neither clear nor load is set,
// the register holds its value.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset; forces q to zero
//   load   in   capture d on this edge
//   clear  in   capture a bubble on this edge (overrides load)
//   d      in   SW-bit next stage record
//   q      out  SW-bit current stage record

module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int SW = 2 + DEF_REGW + DEF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [SW-1:0] d,
  output logic [SW-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-word pipeline with stall/flush, taps, forwarding and load-use hazard
//
// Purpose: carries one decoded control word and its destination register
// through DEPTH stages, with a valid bit in every stage. It also produces
// combinational forward selects and a load-use stall request for the
// instruction in decode.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   decoded instruction present
//   in_ctrl      in   WIDTH-bit decoded control word
//   in_rd        in   REGW-bit destination register
//   in_wr        in   instruction writes in_rd
//   stall        in   hold stage 0, insert a bubble into stage 1
//   flush        in   bubble stage 0 and stage 1, drop the incoming instruction
//   src_a/src_b  in   REGW-bit source registers of the instruction in decode
//   chk_en       in   enable forward and hazard comparison
//   stage_valid  out  DEPTH valid bits, bit 0 is the youngest stage
//   stage_ctrl   out  DEPTH x WIDTH control words, stage k at [k*WIDTH +: WIDTH]
//   stage_rd     out  DEPTH x REGW destinations, stage k at [k*REGW +: REGW]
//   fwd_a/fwd_b  out  0 = no forward, k = forward from stage k-1
//   hazard       out  load-use stall request (the integrator drives stall from it)

module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int REGW     = DEF_REGW,
  parameter int ZERO_REG = 31,
  parameter int LOAD_BIT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_ctrl,
  input  logic [REGW-1:0]            in_rd,
  input  logic                       in_wr,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [REGW-1:0]            src_a,
  input  logic [REGW-1:0]            src_b,
  input  logic                       chk_en,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_ctrl,
  output logic [DEPTH*REGW-1:0]      stage_rd,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b,
  output logic                       hazard
);

  localparam int SW = 2 + REGW + WIDTH;
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [REGW-1:0] ZR = REGW'(ZERO_REG);

  // Bit positions inside a flat stage record {valid, wr, rd, ctrl}.
  localparam int V_BIT  = SW - 1;
  localparam int WR_BIT = SW - 2;
  localparam int RD_LSB = WIDTH;

  logic [SW-1:0]    st_d [DEPTH];
  logic [SW-1:0]    st_q [DEPTH];
  logic [DEPTH-1:0] st_load;
  logic [DEPTH-1:0] st_clear;
  logic [DEPTH-1:0] stage_wr;

  // Stages 2 and above always advance. Only the two youngest stages react
  // to stall and flush. flush overrides stall, which means a stall+flush
  // cycle behaves exactly like a plain flush.
  always_comb begin
    st_load     = '1;
    st_clear    = '0;
    st_load[0]  = ~stall | flush;
    st_clear[0] = flush;
    st_clear[1] = stall | flush;
  end

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign st_d[k] = {in_valid, in_wr, in_rd, in_ctrl};
      end else begin : g_body
        assign st_d[k] = st_q[k-1];
      end

      ctrl_pipe_stage #(
        .SW (SW)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .load  (st_load[k]),
        .clear (st_clear[k]),
        .d     (st_d[k]),
        .q     (st_q[k])
      );

      assign stage_valid[k]                 = st_q[k][V_BIT];
      assign stage_wr[k]                    = st_q[k][WR_BIT];
      assign stage_rd[k*REGW +: REGW]       = st_q[k][RD_LSB +: REGW];
      assign stage_ctrl[k*WIDTH +: WIDTH]   = st_q[k][WIDTH-1:0];
    end
  endgenerate

  // Per-stage match vectors for both source operands. They are padded to
  // MAX_DEPTH so that both paths share one package encoder. Writes to the
  // zero register never forward.
  logic [MAX_DEPTH-1:0] match_a;
  logic [MAX_DEPTH-1:0] match_b;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int s = 0; s < DEPTH; s++) begin
      match_a[s] = chk_en & stage_valid[s] & stage_wr[s]
                   & (stage_rd[s*REGW +: REGW] == src_a) & (src_a != ZR);
      match_b[s] = chk_en & stage_valid[s] & stage_wr[s]
                   & (stage_rd[s*REGW +: REGW] == src_b) & (src_b != ZR);
    end
  end

  assign fwd_a = FW'(fwd_encode(match_a));
  assign fwd_b = FW'(fwd_encode(match_b));

  // Load-use hazard: a load that writes a real register sits in the
  // youngest stage, and the instruction in decode reads that register.
  // The load result is not available to forward yet.
  logic [REGW-1:0] rd0;
  assign rd0 = stage_rd[REGW-1:0];

  assign hazard = chk_en & stage_valid[0] & stage_wr[0] & stage_ctrl[LOAD_BIT]
                  & (rd0 != ZR) & ((rd0 == src_a) | (rd0 == src_b));

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard testbench for ctrl_pipe

module tb_ctrl_pipe;

  localparam logic [15:0] ADD  = 16'h0002;
  localparam logic [15:0] LDUR = 16'h0003;
  localparam logic [15:0] STUR = 16'h0004;

  localparam int S_VALID = 0;
  localparam int S_RD    = 1;
  localparam int S_FA    = 2;
  localparam int S_FB    = 3;
  localparam int S_HZ    = 4;
  localparam int S_CTRL  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [4:0]  in_rd;
  logic        in_wr;
  logic        stall;
  logic        flush;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        chk_en;
  logic [2:0]  stage_valid;
  logic [47:0] stage_ctrl;
  logic [14:0] stage_rd;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        hazard;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ctrl     (in_ctrl),
    .in_rd       (in_rd),
    .in_wr       (in_wr),
    .stall       (stall),
    .flush       (flush),
    .src_a       (src_a),
    .src_b       (src_b),
    .chk_en      (chk_en),
    .stage_valid (stage_valid),
    .stage_ctrl  (stage_ctrl),
    .stage_rd    (stage_rd),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .hazard      (hazard)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    int          idx;
    logic [31:0] exp;
    bit          on_rst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sel, int idx);
    case (sel)
      S_VALID: return 32'(stage_valid);
      S_RD:    return 32'(stage_rd[idx*5 +: 5]);
      S_FA:    return 32'(fwd_a);
      S_FB:    return 32'(fwd_b);
      S_HZ:    return 32'(hazard);
      S_CTRL:  return 32'(stage_ctrl[idx*16 +: 16]);
      default: return 32'hffff_ffff;
    endcase
  endfunction

  // Pop every expectation due at this point and compare it. Entries from an
  // earlier cycle that were never observed count as failures.
  task automatic drain(bit on_rst);
    while (sb.size() > 0 &&
           (sb[0].cyc < cyc || (sb[0].cyc == cyc && sb[0].on_rst == on_rst))) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actual(e.sel, e.idx);
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: never observed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    drain(1'b0);
  end

  always @(negedge reset) begin
    #1;
    drain(1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string n, int sel, int idx, logic [31:0] e, bit r = 1'b0);
    exp_t x;
    x.cyc    = cyc;
    x.name   = n;
    x.sel    = sel;
    x.idx    = idx;
    x.exp    = e;
    x.on_rst = r;
    sb.push_back(x);
  endtask

  task automatic instr(bit v, logic [15:0] c, logic [4:0] r, bit w);
    in_valid = v;
    in_ctrl  = c;
    in_rd    = r;
    in_wr    = w;
  endtask

  initial begin
    reset  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    src_a  = '0;
    src_b  = '0;
    chk_en = 1'b0;
    instr(1'b0, '0, '0, 1'b0);

    tick();  // cycle 1, reset held
    chk_en = 1'b1;
    push("rst_valid", S_VALID, 0, 0);
    push("rst_rd0",   S_RD,    0, 0);
    push("rst_fwd_a", S_FA,    0, 0);
    push("rst_fwd_b", S_FB,    0, 0);
    push("rst_hazard", S_HZ,   0, 0);
    reset = 1'b1;
    instr(1'b1, ADD, 5'd1, 1'b1);

    tick();  // 2: X1
    push("fill1_valid", S_VALID, 0, 3'b001);
    push("fill1_rd0",   S_RD,    0, 1);
    instr(1'b1, ADD, 5'd2, 1'b1);
    tick();  // 3: X2 X1
    push("fill2_valid", S_VALID, 0, 3'b011);
    instr(1'b1, ADD, 5'd3, 1'b1);
    tick();  // 4: X3 X2 X1
    push("fill3_valid", S_VALID, 0, 3'b111);
    push("fill3_rd2",   S_RD,    2, 1);
    instr(1'b1, ADD, 5'd4, 1'b1);
    tick();  // 5: X4 X3 X2
    push("fill4_valid", S_VALID, 0, 3'b111);
    push("fill4_rd2",   S_RD,    2, 2);
    push("fill4_rd1",   S_RD,    1, 3);
    push("fill4_rd0",   S_RD,    0, 4);
    instr(1'b1, ADD, 5'd5, 1'b1);

    tick();  // 6: X5 X4 X3
    src_a = 5'd5;
    push("fwd_a_s0", S_FA, 0, 1);
    instr(1'b0, '0, '0, 1'b0);
    tick();  // 7: - X5 X4
    push("fwd_a_s1", S_FA, 0, 2);
    tick();  // 8: - - X5
    push("fwd_a_s2", S_FA,    0, 3);
    push("drain_valid", S_VALID, 0, 3'b100);
    instr(1'b1, ADD, 5'd5, 1'b1);
    tick();  // 9: X5 - -
    instr(1'b1, ADD, 5'd6, 1'b1);
    tick();  // 10: X6 X5 -
    instr(1'b1, ADD, 5'd5, 1'b1);
    tick();  // 11: X5 X6 X5
    src_a = 5'd6;
    src_b = 5'd5;
    push("fwd_b_youngest", S_FB, 0, 1);
    push("fwd_a_mid",      S_FA, 0, 2);
    push("add_no_hazard",  S_HZ, 0, 0);
    instr(1'b1, LDUR, 5'd7, 1'b1);

    tick();  // 12: LD7 X5 X6
    src_a = 5'd7;
    src_b = 5'd0;
    push("ld_hazard",  S_HZ,   0, 1);
    push("ld_fwd_a",   S_FA,   0, 1);
    push("ld_ctrl0",   S_CTRL, 0, LDUR);
    stall = 1'b1;
    instr(1'b1, ADD, 5'd8, 1'b1);
    tick();  // 13: LD7 - X5 (stalled)
    push("stall_valid",  S_VALID, 0, 3'b101);
    push("stall_rd0",    S_RD,    0, 7);
    push("stall_rd2",    S_RD,    2, 5);
    push("stall_hazard", S_HZ,    0, 1);
    stall = 1'b0;
    tick();  // 14: X8 LD7 -
    push("post_stall_valid",  S_VALID, 0, 3'b011);
    push("post_stall_fwd_a",  S_FA,    0, 2);
    push("post_stall_hazard", S_HZ,    0, 0);
    instr(1'b1, STUR, 5'd9, 1'b0);

    tick();  // 15: ST9 X8 LD7
    src_a = 5'd9;
    src_b = 5'd8;
    push("stur_fwd_a",  S_FA, 0, 0);
    push("stur_hazard", S_HZ, 0, 0);
    push("x8_fwd_b",    S_FB, 0, 2);
    instr(1'b1, LDUR, 5'd31, 1'b1);
    tick();  // 16: LD31 ST9 X8
    src_a = 5'd31;
    src_b = 5'd9;
    push("xzr_fwd_a",  S_FA, 0, 0);
    push("xzr_fwd_b",  S_FB, 0, 0);
    push("xzr_hazard", S_HZ, 0, 0);
    instr(1'b1, ADD, 5'd10, 1'b1);

    tick();  // 17: X10 LD31 ST9
    push("pre_flush_valid", S_VALID, 0, 3'b111);
    stall = 1'b1;
    flush = 1'b1;
    instr(1'b1, ADD, 5'd11, 1'b1);
    tick();  // 18: - - LD31
    push("flush_valid", S_VALID, 0, 3'b100);
    push("flush_rd2",   S_RD,    2, 31);
    push("flush_rd0",   S_RD,    0, 0);
    push("flush_ctrl2", S_CTRL,  2, LDUR);
    stall = 1'b0;
    flush = 1'b0;
    instr(1'b1, ADD, 5'd12, 1'b1);
    tick();  // 19: X12 - -
    push("after_flush_valid", S_VALID, 0, 3'b001);
    push("after_flush_rd0",   S_RD,    0, 12);
    instr(1'b1, ADD, 5'd13, 1'b1);

    tick();  // 20: X13 X12 -
    push("pre_rst_valid", S_VALID, 0, 3'b011);
    push("async_rst_valid", S_VALID, 0, 0, 1'b1);
    push("async_rst_rd0",   S_RD,    0, 0, 1'b1);
    instr(1'b1, ADD, 5'd14, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    tick();  // 21: reset still low
    push("rst_hold_valid", S_VALID, 0, 0);
    reset = 1'b1;
    tick();  // 22: X14 - -
    push("recover_valid", S_VALID, 0, 3'b001);
    push("recover_rd0",   S_RD,    0, 14);
    instr(1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never observed (due cycle %0d)", e.name, e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
